// File: rtl/brq_dmem_pkg.sv
// Shared types and lane helpers for the Buraq-mini data-memory responder.
// The funct3 size codes, the FSM states and the byte-lane pure functions used by the top.
package brq_dmem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Illegal funct3 codes and misaligned H/W accesses are both rejected here.
    function automatic logic access_legal(input logic [2:0] code, input logic [1:0] lo);
        case (code)
            SZ_B, SZ_BU: return 1'b1;
            SZ_H, SZ_HU: return ~lo[0];
            SZ_W:        return (lo == 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] code, input logic [1:0] lo);
        case (code)
            SZ_B, SZ_BU: return 4'b0001 << lo;
            SZ_H, SZ_HU: return lo[1] ? 4'b1100 : 4'b0011;
            SZ_W:        return 4'b1111;
            default:     return 4'b0000;
        endcase
    endfunction

    // Store data arrives right-aligned; copy it into every lane it could land in.
    function automatic logic [31:0] store_replicate(input logic [2:0] code, input logic [31:0] d);
        case (code)
            SZ_B, SZ_BU: return {4{d[7:0]}};
            SZ_H, SZ_HU: return {2{d[15:0]}};
            default:     return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] code, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (code)
            SZ_B:    return {{24{sh[7]}}, sh[7:0]};
            SZ_BU:   return {24'h0, sh[7:0]};
            SZ_H:    return {{16{sh[15]}}, sh[15:0]};
            SZ_HU:   return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/brq_dmem_ram.sv
// Byte-write-enable single-port synchronous RAM, four 8-bit lanes, registered read-before-write.
// One access per enabled clock; no reset so it maps onto block RAM.
module brq_dmem_ram #(
    parameter int AddrWidth = 13
) (
    input  logic                 i_clk,
    input  logic                 i_en,
    input  logic [3:0]           i_we,
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [31:0]          i_wdat,
    output logic [31:0]          o_rdat
);

    logic [31:0] r_mem [0:(1<<AddrWidth)-1];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdat[8*i +: 8];
            end
            o_rdat <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/brq_dmem_responder.sv
// Data-memory responder: word RAM with byte-lane merge; response pulse WaitStates+1 cycles after acceptance.
// Busy from acceptance+1 to the response; inputs ignored while busy. BRQ_DMEM_MMIO_EN adds an MMIO register.
module brq_dmem_responder
    import brq_dmem_pkg::*;
#(
    parameter int                   DataWidth  = 32,
    parameter int                   AddrWidth  = 15,
    parameter int                   WaitStates = 0,
    parameter logic [AddrWidth-1:0] MmioAddr   = 15'h7FFC
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic [AddrWidth-1:0] Data_mem_address,
    input  logic                 Data_mem_read_en,
    input  logic                 Data_mem_write_en,
    input  logic [2:0]           ldst_byte_en,
    input  logic [DataWidth-1:0] Data_mem_dataIn,
    output logic [DataWidth-1:0] Data_mem_dataOut,
    output logic                 dmem_rvalid,
    output logic                 dmem_wdone,
    output logic                 dmem_busy,
    output logic                 dmem_misalign,
    output logic [DataWidth-1:0] mmio_out
);

    localparam int         WordAw = AddrWidth - 2;
    localparam logic [3:0] WsLast = 4'(WaitStates - 1);
`ifdef BRQ_DMEM_MMIO_EN
    localparam logic MmioEn = 1'b1;
`else
    localparam logic MmioEn = 1'b0;
`endif

    state_e               r_state;
    logic [3:0]           r_cnt;
    logic [AddrWidth-1:0] r_addr;
    logic [2:0]           r_code;
    logic [3:0]           r_mask;
    logic [31:0]          r_wdat;
    logic                 r_wr;
    logic                 r_mmio;
    logic                 r_misalign;
    logic [31:0]          r_dout;
    logic [31:0]          r_mmio_reg;

    logic                 w_idle;
    logic                 w_req;
    logic                 w_legal;
    logic                 w_accept;
    logic                 w_in_resp;
    logic                 w_go_resp;
    logic [AddrWidth-1:0] w_addr;
    logic [3:0]           w_mask;
    logic [31:0]          w_wdat;
    logic                 w_wr;
    logic                 w_mmio_hit;
    logic                 w_ram_en;
    logic [3:0]           w_ram_we;
    logic [31:0]          w_ram_q;
    logic [31:0]          w_ld_word;
    logic [31:0]          w_ld_ext;

    assign w_idle    = (r_state == IDLE);
    assign w_in_resp = (r_state == RESP);
    assign w_req     = Data_mem_read_en | Data_mem_write_en;
    assign w_legal   = access_legal(ldst_byte_en, Data_mem_address[1:0]);
    assign w_accept  = w_idle & w_req & w_legal;

    // With no wait states the RAM is hit on the acceptance edge, so use the live request there.
    assign w_addr = w_idle ? Data_mem_address : r_addr;
    assign w_mask = w_idle ? lane_mask(ldst_byte_en, Data_mem_address[1:0]) : r_mask;
    assign w_wdat = w_idle ? store_replicate(ldst_byte_en, Data_mem_dataIn) : r_wdat;
    assign w_wr   = w_idle ? Data_mem_write_en : r_wr;

    assign w_mmio_hit = MmioEn & (w_addr[AddrWidth-1:2] == MmioAddr[AddrWidth-1:2]);

    assign w_go_resp = ~brq_rst & ((w_accept & (WaitStates == 0)) |
                                   ((r_state == WAIT) & (r_cnt == WsLast)));

    assign w_ram_en = w_go_resp & ~w_mmio_hit;
    assign w_ram_we = w_wr ? w_mask : 4'b0000;

    brq_dmem_ram #(
        .AddrWidth (WordAw)
    ) u_ram (
        .i_clk  (brq_clk),
        .i_en   (w_ram_en),
        .i_we   (w_ram_we),
        .i_addr (w_addr[AddrWidth-1:2]),
        .i_wdat (w_wdat),
        .o_rdat (w_ram_q)
    );

    always_ff @(posedge brq_clk or posedge brq_rst) begin
        if (brq_rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_code     <= 3'b000;
            r_mask     <= 4'b0000;
            r_wdat     <= 32'h0;
            r_wr       <= 1'b0;
            r_mmio     <= 1'b0;
            r_misalign <= 1'b0;
            r_dout     <= 32'h0;
            r_mmio_reg <= 32'h0;
        end else begin
            r_misalign <= w_idle & w_req & ~w_legal;
            if (w_accept) begin
                r_addr <= Data_mem_address;
                r_code <= ldst_byte_en;
                r_mask <= w_mask;
                r_wdat <= w_wdat;
                r_wr   <= Data_mem_write_en;
                r_mmio <= w_mmio_hit;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= 4'd0;
                        r_state <= (WaitStates == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == WsLast) r_state <= RESP;
                    else                 r_cnt   <= r_cnt + 4'd1;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_in_resp & ~r_wr) r_dout <= w_ld_ext;
            if (w_go_resp & w_mmio_hit & w_wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_mask[i]) r_mmio_reg[8*i +: 8] <= w_wdat[8*i +: 8];
                end
            end
        end
    end

    // The RAM output is already registered, so load data is presented during RESP and then held.
    assign w_ld_word = r_mmio ? r_mmio_reg : w_ram_q;
    assign w_ld_ext  = load_extend(r_code, r_addr[1:0], w_ld_word);

    assign dmem_busy        = ~w_idle;
    assign dmem_rvalid      = w_in_resp & ~r_wr;
    assign dmem_wdone       = w_in_resp & r_wr;
    assign dmem_misalign    = r_misalign;
    assign Data_mem_dataOut = dmem_rvalid ? w_ld_ext : r_dout;

`ifdef BRQ_DMEM_MMIO_EN
    assign mmio_out = r_mmio_reg;
`else
    assign mmio_out = '0;
`endif

endmodule

// File: tb/tb_brq_dmem_responder.sv
// Bench for brq_dmem_responder: one instance with no wait states, one with three.
// Directed vector table plus randomized traffic against a byte-array reference model.
module tb_brq_dmem_responder;

`ifdef BRQ_DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [1:0]       rd_en, wr_en, busy, rvalid, wdone, mis;
    logic [1:0][2:0]  code_v;
    logic [1:0][14:0] addr_v;
    logic [1:0][31:0] din_v, dout_v, mmio_v;

    always #5 clk = ~clk;

    brq_dmem_responder #(.WaitStates(0)) u_dut0 (
        .brq_clk(clk), .brq_rst(rst),
        .Data_mem_address(addr_v[0]), .Data_mem_read_en(rd_en[0]), .Data_mem_write_en(wr_en[0]),
        .ldst_byte_en(code_v[0]), .Data_mem_dataIn(din_v[0]), .Data_mem_dataOut(dout_v[0]),
        .dmem_rvalid(rvalid[0]), .dmem_wdone(wdone[0]), .dmem_busy(busy[0]),
        .dmem_misalign(mis[0]), .mmio_out(mmio_v[0])
    );

    brq_dmem_responder #(.WaitStates(3)) u_dut3 (
        .brq_clk(clk), .brq_rst(rst),
        .Data_mem_address(addr_v[1]), .Data_mem_read_en(rd_en[1]), .Data_mem_write_en(wr_en[1]),
        .ldst_byte_en(code_v[1]), .Data_mem_dataIn(din_v[1]), .Data_mem_dataOut(dout_v[1]),
        .dmem_rvalid(rvalid[1]), .dmem_wdone(wdone[1]), .dmem_busy(busy[1]),
        .dmem_misalign(mis[1]), .mmio_out(mmio_v[1])
    );

    // Reference model: byte-addressed memory, MMIO word and last load value, per instance.
    logic [7:0]  mb [2][32768];
    logic [31:0] mm [2];
    logic [31:0] last_ld [2];
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  code;
        logic [14:0] a;
        logic [31:0] dat;
        logic [2:0]  kind;   // {rvalid, wdone, misalign}
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h required %h", nm, fld, got, exp);
        end
    endtask

    task automatic drive(input int d, input bit rd, input bit wr, input logic [2:0] code,
                         input logic [14:0] a, input logic [31:0] dat);
        rd_en[d]  = rd;
        wr_en[d]  = wr;
        code_v[d] = code;
        addr_v[d] = a;
        din_v[d]  = dat;
    endtask

    function automatic bit is_mmio(input int a);
        return MMIO_EN && ((a >> 2) == (32'h7FFC >> 2));
    endfunction

    function automatic logic [7:0] rbyte(input int d, input int a);
        if (is_mmio(a)) return mm[d][8*(a%4) +: 8];
        return mb[d][a];
    endfunction

    task automatic wbyte(input int d, input int a, input logic [7:0] b);
        if (is_mmio(a)) mm[d][8*(a%4) +: 8] = b;
        else            mb[d][a] = b;
    endtask

    task automatic model_step(input int d, input bit wr, input logic [2:0] code, input logic [14:0] a,
                              input logic [31:0] dat, output logic [2:0] kind, output logic [31:0] ed);
        int sz;
        bit uns;
        logic [31:0] v;
        uns = code[2];
        case (code)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            3'b010:         sz = 4;
            default:        sz = 0;
        endcase
        if (sz == 0 || (int'(a) % sz) != 0) begin
            kind = 3'b001;
            ed   = last_ld[d];
        end else if (wr) begin
            for (int i = 0; i < sz; i++) wbyte(d, int'(a) + i, dat[8*i +: 8]);
            kind = 3'b010;
            ed   = last_ld[d];
        end else begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = rbyte(d, int'(a) + i);
            if (!uns && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
            last_ld[d] = v;
            kind = 3'b100;
            ed   = v;
        end
    endtask

    task automatic do_req(input int d, input bit rd, input bit wr, input logic [2:0] code,
                          input logic [14:0] a, input logic [31:0] dat, input bit toggle,
                          output logic [2:0] kind, output int lat, output int bcnt,
                          output logic [31:0] od, output logic acc_busy);
        @(negedge clk);
        acc_busy = busy[d];
        drive(d, rd, wr, code, a, dat);
        kind = 3'b000;
        lat  = 0;
        bcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) drive(d, 1'b0, 1'b0, 3'b000, 15'h0, 32'h0);
            if (busy[d]) bcnt++;
            if (rvalid[d] | wdone[d] | mis[d]) begin
                kind = {rvalid[d], wdone[d], mis[d]};
                lat  = c;
                break;
            end
            if (toggle)
                drive(d, 1'($urandom), 1'($urandom), 3'($urandom), 15'($urandom_range(0, 63)), $urandom);
        end
        od = dout_v[d];
        drive(d, 1'b0, 1'b0, 3'b000, 15'h0, 32'h0);
    endtask

    task automatic run_req(input int d, input bit rd, input bit wr, input logic [2:0] code,
                           input logic [14:0] a, input logic [31:0] dat, input bit toggle,
                           input logic [2:0] ek, input logic [31:0] ed, input string tag);
        logic [2:0]  kind;
        logic [31:0] od;
        logic        ab;
        int lat, bcnt, ws, el, eb;
        ws = (d == 0) ? 0 : 3;
        el = (ek == 3'b001) ? 1 : ws + 1;
        eb = (ek == 3'b001) ? 0 : ws + 1;
        do_req(d, rd, wr, code, a, dat, toggle, kind, lat, bcnt, od, ab);
        chk(tag, "acc_busy", 32'(ab), 32'h0);
        chk(tag, "kind", 32'(kind), 32'(ek));
        chk(tag, "dout", od, ed);
        chk(tag, "latency", lat, el);
        chk(tag, "busy_cycles", bcnt, eb);
        chk(tag, "mmio", mmio_v[d], mm[d]);
    endtask

    task automatic add(input bit rd, input bit wr, input logic [2:0] code, input logic [14:0] a,
                       input logic [31:0] dat, input logic [2:0] kind, input logic [31:0] dout);
        vec_t v;
        v.rd = rd; v.wr = wr; v.code = code; v.a = a; v.dat = dat; v.kind = kind; v.dout = dout;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        logic [2:0]  ek;
        logic [31:0] ed;
        logic [31:0] dat;
        logic [2:0]  c;
        logic [14:0] a;
        logic [2:0]  codes [8];
        int r;
        bit tg;

        codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110};
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 1'b0, 3'b000, 15'h0, 32'h0);
            mm[d] = 32'h0;
            last_ld[d] = 32'h0;
        end
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset%0d", d), "ctl", 32'({busy[d], rvalid[d], wdone[d], mis[d]}), 32'h0);
            chk($sformatf("reset%0d", d), "dout", dout_v[d], 32'h0);
            chk($sformatf("reset%0d", d), "mmio", mmio_v[d], 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("post_reset%0d", d), "ctl", 32'({busy[d], rvalid[d], wdone[d], mis[d]}), 32'h0);

        // Directed vectors on the zero-wait instance; expected values derived by hand.
        add(0, 1, 3'b010, 15'h0004, 32'hDEADBEEF, 3'b010, 32'h00000000);
        add(1, 0, 3'b010, 15'h0004, 32'h0,        3'b100, 32'hDEADBEEF);
        add(0, 1, 3'b000, 15'h0005, 32'hFFFFFF80, 3'b010, 32'hDEADBEEF);
        add(1, 0, 3'b000, 15'h0005, 32'h0,        3'b100, 32'hFFFFFF80);
        add(1, 0, 3'b100, 15'h0005, 32'h0,        3'b100, 32'h00000080);
        add(1, 0, 3'b010, 15'h0004, 32'h0,        3'b100, 32'hDEAD80EF);
        add(0, 1, 3'b001, 15'h0006, 32'hABCD1234, 3'b010, 32'hDEAD80EF);
        add(1, 0, 3'b101, 15'h0006, 32'h0,        3'b100, 32'h00001234);
        add(1, 0, 3'b001, 15'h0003, 32'h0,        3'b001, 32'h00001234);
        add(1, 0, 3'b010, 15'h0004, 32'h0,        3'b100, 32'h123480EF);
        add(0, 1, 3'b001, 15'h0004, 32'h00008001, 3'b010, 32'h123480EF);
        add(1, 0, 3'b001, 15'h0004, 32'h0,        3'b100, 32'hFFFF8001);
        add(0, 1, 3'b010, 15'h0006, 32'h0,        3'b001, 32'hFFFF8001);
        add(1, 0, 3'b011, 15'h0004, 32'h0,        3'b001, 32'hFFFF8001);
        add(0, 1, 3'b110, 15'h0004, 32'h0,        3'b001, 32'hFFFF8001);
        add(1, 0, 3'b010, 15'h0004, 32'h0,        3'b100, 32'h12348001);
        add(1, 1, 3'b010, 15'h0008, 32'hCAFEF00D, 3'b010, 32'h12348001);
        add(1, 0, 3'b010, 15'h0008, 32'h0,        3'b100, 32'hCAFEF00D);
        add(1, 0, 3'b100, 15'h000B, 32'h0,        3'b100, 32'h000000CA);
        add(1, 0, 3'b000, 15'h000A, 32'h0,        3'b100, 32'hFFFFFFFE);
        add(1, 0, 3'b101, 15'h0008, 32'h0,        3'b100, 32'h0000F00D);
        add(1, 0, 3'b001, 15'h000A, 32'h0,        3'b100, 32'hFFFFCAFE);
        add(1, 0, 3'b101, 15'h0009, 32'h0,        3'b001, 32'hFFFFCAFE);
        add(0, 1, 3'b010, 15'h7FFC, 32'h000000A5, 3'b010, 32'hFFFFCAFE);
        add(1, 0, 3'b010, 15'h7FFC, 32'h0,        3'b100, 32'h000000A5);
        add(1, 0, 3'b100, 15'h7FFC, 32'h0,        3'b100, 32'h000000A5);
        for (int i = 0; i < tbl.size(); i++) begin
            model_step(0, tbl[i].wr, tbl[i].code, tbl[i].a, tbl[i].dat, ek, ed);
            run_req(0, tbl[i].rd, tbl[i].wr, tbl[i].code, tbl[i].a, tbl[i].dat, 1'b0,
                    tbl[i].kind, tbl[i].dout, $sformatf("tbl%0d", i));
        end

        // Randomized traffic on both instances over a 16-word window.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                dat = $urandom;
                model_step(d, 1'b1, 3'b010, 15'(4*w), dat, ek, ed);
                run_req(d, 1'b0, 1'b1, 3'b010, 15'(4*w), dat, 1'b0, ek, ed, $sformatf("init%0d_%0d", d, w));
            end
            for (int n = 0; n < 150; n++) begin
                r   = $urandom_range(1, 3);
                c   = codes[$urandom_range(0, 7)];
                a   = 15'($urandom_range(0, 63));
                dat = $urandom;
                tg  = (d == 1) && ($urandom_range(0, 1) == 1);
                model_step(d, r[1], c, a, dat, ek, ed);
                run_req(d, r[0], r[1], c, a, dat, tg, ek, ed, $sformatf("rnd%0d_%0d", d, n));
            end
        end

        // Three wait states with inputs toggling while busy.
        model_step(1, 1'b0, 3'b010, 15'h0004, 32'h0, ek, ed);
        run_req(1, 1'b1, 1'b0, 3'b010, 15'h0004, 32'h0, 1'b1, ek, ed, "ws3_lw");

        // Reset during the WAIT phase of a store: discarded, outputs clear at once.
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 3'b010, 15'h0008, 32'h5555AAAA);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 3'b000, 15'h0, 32'h0);
        chk("rst_mid", "busy_before", 32'(busy[1]), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid", "ctl1", 32'({busy[1], rvalid[1], wdone[1], mis[1]}), 32'h0);
        chk("rst_mid", "dout1", dout_v[1], 32'h0);
        chk("rst_mid", "dout0", dout_v[0], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            last_ld[d] = 32'h0;
            mm[d] = 32'h0;
        end
        chk("rst_mid", "ctl_after", 32'({busy[1], rvalid[1], wdone[1], mis[1]}), 32'h0);
        model_step(1, 1'b0, 3'b010, 15'h0008, 32'h0, ek, ed);
        run_req(1, 1'b1, 1'b0, 3'b010, 15'h0008, 32'h0, 1'b0, ek, ed, "rst_lw8");
        model_step(0, 1'b0, 3'b010, 15'h0008, 32'h0, ek, ed);
        run_req(0, 1'b1, 1'b0, 3'b010, 15'h0008, 32'h0, 1'b0, ek, ed, "rst_lw8_d0");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/brq_dmem_responder.md
Name: brq_dmem_responder

Overview:
- Data-memory responder for the Buraq-mini RV32IM core; the target end of the core's data-memory port.
- Accepts the core's load/store requests: byte address, read/write enables, funct3-coded access size, store data.
- Holds a word-organised RAM with byte-lane write merge. Returns load data sign- or zero-extended and right-aligned.
- Programmable wait states; misaligned-access detection; optional memory-mapped output register.

Parameters:
DataWidth, 32, data word width in bits (fixed at 32 for RV32)
AddrWidth, 15, byte-address width; RAM depth = 2**(AddrWidth-2) words
WaitStates, 0, extra cycles inserted before each response (0..15)
MmioAddr, 15'h7FFC, word-aligned byte address of the MMIO register (used only with the macro)

Ports:
brq_clk  in  1  clock, rising edge
brq_rst  in  1  reset, asynchronous, active-high
Data_mem_address  in  AddrWidth  byte address from the core
Data_mem_read_en  in  1  load request
Data_mem_write_en  in  1  store request
ldst_byte_en  in  3  funct3 access code: 000 B, 001 H, 010 W, 100 BU, 101 HU
Data_mem_dataIn  in  DataWidth  store data, right-aligned
Data_mem_dataOut  out  DataWidth  load data, extended and right-aligned
dmem_rvalid  out  1  one-cycle pulse: load data valid
dmem_wdone  out  1  one-cycle pulse: store committed
dmem_busy  out  1  request in flight; core must hold or stall
dmem_misalign  out  1  one-cycle pulse: misaligned or illegal-code access, dropped
mmio_out  out  DataWidth  MMIO register value (0 when the macro is off)

Behaviour:
- Clock is brq_clk; reset is brq_rst, asynchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, wait counter 0. RAM contents are not reset.
- A request is accepted in IDLE when read_en or write_en is 1.
- At acceptance, address, code, data and direction are registered. Inputs are ignored while busy.
- read_en and write_en both 1: the write wins and the read is dropped. No error flag.
- Alignment rules:
  - H/HU needs addr[0]=0.
  - W needs addr[1:0]=0.
  - Codes 011, 110 and 111 are illegal.
  - A violating request pulses dmem_misalign the cycle after acceptance, makes no RAM change, gives no rvalid/wdone, and Data_mem_dataOut keeps its old value. FSM stays in IDLE.
- FSM states:
  - IDLE -> WAIT when WaitStates>0; IDLE -> RESP when WaitStates=0.
  - WAIT counts WaitStates cycles, then -> RESP.
  - RESP -> IDLE after one cycle.
- dmem_busy is 1 in WAIT and RESP. It is 0 in IDLE, including the acceptance cycle.
- Store lane merge: the word is at index addr[AddrWidth-1:2].
  - SB writes lane addr[1:0] with dataIn[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with dataIn[15:0].
  - SW writes all four lanes.
  - Other lanes are unchanged.
  - The RAM write occurs on the RESP-entry edge. dmem_wdone pulses during RESP.
- Loads: the RAM is read on the RESP-entry edge and the selected lane(s) are extracted.
  - B/H sign-extend; BU/HU zero-extend.
  - Data_mem_dataOut is registered and updated in RESP alongside dmem_rvalid.
  - The value holds until the next completed load.
- Latency with WaitStates=0: a request at cycle N gives its response pulse at N+1. In general, the response pulse comes WaitStates+1 cycles after acceptance.
- Read after write to the same word, back to back, returns the new data (the store commits before the next acceptance).
- Reset asserted mid-WAIT or mid-RESP: return to IDLE immediately. A pending store that has not reached RESP entry is discarded. No pulses.
- Address wrap: only addr[AddrWidth-1:2] indexes the RAM; there are no out-of-range responses.

Optional Feature:
BRQ_DMEM_MMIO_EN
- Defined: a word access at MmioAddr targets a DataWidth register (reset 0) instead of the RAM. Stores merge lanes into the register; loads read it with the same extension rules. mmio_out drives the register continuously.
- Not defined: MmioAddr is ordinary RAM and mmio_out is tied to 0.

Decomposition:
- Shared package brq_dmem_pkg:
  - enum for the funct3 size codes (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU)
  - FSM state enum (IDLE, WAIT, RESP)
  - function lane_mask(code, addr[1:0]) returning a 4-bit write mask
  - function load_extend(code, addr[1:0], word)
- One sub-module: brq_dmem_ram, a byte-write-enable single-port synchronous RAM (4 byte lanes, registered read) that infers BRAM.

Test Plan:
- WaitStates=0: SW 0x0000_0004 <- 0xDEADBEEF, then LW 0x4 -> wdone at N+1; next load gives dataOut 0xDEADBEEF with rvalid at M+1.
- SB 0x5 <- 0x80, then LB 0x5 -> 0xFFFF_FF80; LBU 0x5 -> 0x0000_0080; LW 0x4 -> 0xDEAD80EF.
- SH 0x6 <- 0x1234, LHU 0x6 -> 0x0000_1234. LH at address 0x3 -> dmem_misalign pulse, no rvalid, dataOut unchanged.
- WaitStates=3: LW -> busy high for exactly 4 cycles, rvalid on the 4th; inputs toggled while busy are ignored.
- Assert brq_rst during WAIT of an SW to 0x8 -> outputs 0 at once; later LW 0x8 returns the prior contents.
- With BRQ_DMEM_MMIO_EN: SW MmioAddr <- 0x0000_00A5 -> mmio_out=0xA5; LW MmioAddr -> 0xA5; RAM word at 0x7FFC is untouched.
